dmem_arbiter: RTL

Single-ported data-memory arbiter sharing the data memory between the pipeline's MEM stage (core port) and a DMA/program-loader port (dma port). It parks on the core for zero-latency single-cycle loads and stores. It grants the DMA bounded bursts and stalls the core while the DMA owns the memory. The block sits between the MEM/WB pipeline stage, the loader and the data memory, all clocked on `clk1`.

---
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Single-ported data-memory arbiter: parks on the MEM-stage core port and grants bounded DMA bursts.
// Optional starvation guard enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int LEN_W        = 8,
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [LEN_W-1:0]  dma_len,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              dma_done,
  output logic              mem_en,
  output logic              mem_en_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {CORE = 1'b0, DMA = 1'b1} owner_e;

  owner_e            owner_q, owner_d;
  logic [LEN_W-1:0]  rem_q, rem_d, len_eff, rem_eff;
  logic [BW-1:0]     burst_q, burst_d;
  logic              rule1, force_dma;

  assign len_eff = (dma_len == '0) ? LEN_W'(1) : dma_len;
  assign rem_eff = (rem_q != '0) ? rem_q : len_eff;

`ifdef DMEM_ARB_STARVE_EN
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!dma_req || owner_q == DMA) starve_d = '0;
    else if (32'(starve_q) < 32'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk1) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  assign force_dma = dma_req && (32'(starve_q) >= 32'(STARVE_LIMIT));
`else
  assign force_dma = 1'b0;
`endif

  // state register
  always_ff @(posedge clk1) begin
    if (reset) owner_q <= CORE;
    else       owner_q <= owner_d;
  end

  // next owner: keep the DMA only while its grant still has budget, otherwise
  // fall back to CORE for at least one cycle before re-arbitrating
  always_comb begin
    rule1 = (owner_q == DMA) && dma_ack && (rem_eff > LEN_W'(1)) &&
            ((32'(burst_q) + 32'd1) < 32'(MAX_BURST)) && dma_req;
    owner_d = CORE;
    if (rule1)
      owner_d = DMA;
    else if (owner_q == CORE && (force_dma || (dma_req && !core_req)))
      owner_d = DMA;
  end

  // output/datapath
  always_comb begin
    core_ack  = 1'b0;
    dma_ack   = 1'b0;
    mem_en    = 1'b0;
    mem_en_w  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (owner_q == CORE && core_req) begin
        core_ack  = 1'b1;
        mem_en    = 1'b1;
        mem_en_w  = core_we;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end else if (owner_q == DMA && dma_req) begin
        dma_ack   = 1'b1;
        mem_en    = 1'b1;
        mem_en_w  = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
    end
  end

  assign core_stall = core_req & ~core_ack;
  assign dma_done   = dma_ack & (rem_eff == LEN_W'(1));
  assign core_rdata = mem_rdata;
  assign dma_rdata  = mem_rdata;

  // rem survives a dropped dma_req so the same transfer resumes on the next grant
  always_comb begin
    rem_d = rem_q;
    if (dma_ack) rem_d = rem_eff - LEN_W'(1);
    burst_d = burst_q;
    if (owner_d == CORE || owner_q == CORE) burst_d = '0;
    else if (dma_ack)                       burst_d = burst_q + BW'(1);
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      rem_q   <= '0;
      burst_q <= '0;
    end else begin
      rem_q   <= rem_d;
      burst_q <= burst_d;
    end
  end
endmodule
